// File: rtl/id_stage_p.sv
// id_stage_p: instruction decode stage with operand forwarding and jump flush.
// Optional load-use interlock enabled by defining ID_LOADUSE_STALL_EN.
module id_stage_p #(
   parameter int unsigned DW         = 16,
   parameter int unsigned IMM_SIGNED = 0
) (
   input  logic            clock,
   input  logic            reset,
   input  logic            state,
   input  logic [15:0]     id_ir,
   input  logic [15:0]     mem_ir,
   input  logic [15:0]     wb_ir,
   input  logic [DW-1:0]   ALUo,
   input  logic [DW-1:0]   reg_C,
   input  logic [DW-1:0]   reg_C1,
   input  logic [DW-1:0]   d_datain,
   input  logic [8*DW-1:0] gr_flat,
   input  logic            jump,
   output logic [15:0]     ex_ir,
   output logic [DW-1:0]   reg_A,
   output logic [DW-1:0]   reg_B,
   output logic [DW-1:0]   smdr,
   output logic            id_stall
);

   localparam logic       EXEC     = 1'b1;
   localparam logic [4:0] OP_NOP   = 5'd0;
   localparam logic [4:0] OP_HALT  = 5'd1;
   localparam logic [4:0] OP_LOAD  = 5'd2;
   localparam logic [4:0] OP_STORE = 5'd3;
   localparam logic [4:0] OP_MOVI  = 5'd4;
   localparam logic [4:0] OP_ADD   = 5'd5;
   localparam logic [4:0] OP_ADDI  = 5'd6;
   localparam logic [4:0] OP_ADDC  = 5'd7;
   localparam logic [4:0] OP_SUB   = 5'd8;
   localparam logic [4:0] OP_SUBI  = 5'd9;
   localparam logic [4:0] OP_SUBC  = 5'd10;
   localparam logic [4:0] OP_CMP   = 5'd11;
   localparam logic [4:0] OP_AND   = 5'd12;
   localparam logic [4:0] OP_OR    = 5'd13;
   localparam logic [4:0] OP_XOR   = 5'd14;
   localparam logic [4:0] OP_SHL   = 5'd15;
   localparam logic [4:0] OP_SHR   = 5'd16;
   localparam logic [4:0] OP_CAL   = 5'd17;
   localparam logic [4:0] OP_CAR   = 5'd18;
   localparam logic [4:0] OP_JUMP  = 5'd19;
   localparam logic [4:0] OP_JZ    = 5'd20;
   localparam logic [4:0] OP_JNZ   = 5'd21;
   localparam logic [4:0] OP_JS    = 5'd22;
   localparam logic [4:0] OP_JNS   = 5'd23;
   localparam logic [4:0] OP_JC    = 5'd24;
   localparam logic [4:0] OP_JNC   = 5'd25;

   function automatic logic is_wr(input logic [4:0] op);
      return op inside {OP_CAR, OP_MOVI, OP_ADD, OP_ADDI, OP_ADDC, OP_SUB, OP_SUBI,
                        OP_SUBC, OP_AND, OP_OR, OP_XOR, OP_SHL, OP_SHR, OP_CAL};
   endfunction

   function automatic logic is_a_hi(input logic [4:0] op);
      return op inside {OP_JZ, OP_JNZ, OP_JS, OP_JNS, OP_JC, OP_JNC, OP_ADDI, OP_SUBI, OP_MOVI};
   endfunction

   function automatic logic is_a_lo(input logic [4:0] op);
      return op inside {OP_LOAD, OP_STORE, OP_ADD, OP_ADDC, OP_SUB, OP_SUBC, OP_CMP,
                        OP_AND, OP_OR, OP_XOR, OP_SHL, OP_SHR, OP_CAL, OP_CAR};
   endfunction

   function automatic logic is_b_fwd(input logic [4:0] op);
      return op inside {OP_ADD, OP_ADDC, OP_SUB, OP_SUBC, OP_CMP, OP_AND, OP_OR, OP_XOR};
   endfunction

   function automatic logic is_b_imm4(input logic [4:0] op);
      return op inside {OP_LOAD, OP_SHL, OP_SHR, OP_CAL, OP_CAR, OP_STORE};
   endfunction

   logic [4:0]    w_id_op, w_ex_op, w_mem_op, w_wb_op;
   logic [DW-1:0] w_gr [8];
   logic [2:0]    w_src_a;
   logic          w_use_a, w_use_b, w_use_s;
   logic [DW-1:0] w_fwd_a, w_fwd_b, w_fwd_s, w_imm4, w_imm8;
   logic          w_flush, w_hazard;
   logic          w_unused;

   assign w_id_op  = id_ir[15:11];
   assign w_ex_op  = ex_ir[15:11];
   assign w_mem_op = mem_ir[15:11];
   assign w_wb_op  = wb_ir[15:11];
   assign w_unused = &{1'b0, mem_ir[7:0], wb_ir[7:0]};

   for (genvar n = 0; n < 8; n++) begin : g_gr
      assign w_gr[n] = gr_flat[n*DW +: DW];
   end

   // Youngest in-flight producer of a register wins; fall back to the register file.
   function automatic logic [DW-1:0] fwd(input logic [2:0] src);
      if (is_wr(w_ex_op) && ex_ir[10:8] == src)                          return ALUo;
      if (is_wr(w_mem_op) && mem_ir[10:8] == src)                        return reg_C;
      if (w_mem_op == OP_LOAD && mem_ir[10:8] == src)                    return d_datain;
      if ((is_wr(w_wb_op) || w_wb_op == OP_LOAD) && wb_ir[10:8] == src) return reg_C1;
      return w_gr[src];
   endfunction

   assign w_src_a = is_a_hi(w_id_op) ? id_ir[10:8] : id_ir[6:4];
   assign w_use_a = is_a_hi(w_id_op) | is_a_lo(w_id_op);
   assign w_use_b = is_b_fwd(w_id_op);
   assign w_use_s = (w_id_op == OP_STORE);
   assign w_fwd_a = fwd(w_src_a);
   assign w_fwd_b = fwd(id_ir[2:0]);
   assign w_fwd_s = fwd(id_ir[10:8]);
   assign w_imm4  = {{(DW-4){1'b0}}, id_ir[3:0]};
   assign w_imm8  = (IMM_SIGNED != 0) ? {{(DW-8){id_ir[7]}}, id_ir[7:0]}
                                      : {{(DW-8){1'b0}}, id_ir[7:0]};
   assign w_flush = jump | (w_id_op == OP_JUMP);

`ifdef ID_LOADUSE_STALL_EN
   // A load in EX cannot be forwarded yet; bubble one cycle so it arrives via d_datain.
   assign w_hazard = (w_ex_op == OP_LOAD) &&
                     ((w_use_a && ex_ir[10:8] == w_src_a)     ||
                      (w_use_b && ex_ir[10:8] == id_ir[2:0])  ||
                      (w_use_s && ex_ir[10:8] == id_ir[10:8]));
`else
   assign w_hazard = 1'b0;
`endif

   assign id_stall = reset & w_hazard & ~w_flush;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         ex_ir <= '0;
         reg_A <= '0;
         reg_B <= '0;
         smdr  <= '0;
      end else if (state == EXEC) begin
         if (w_flush || w_hazard) begin
            ex_ir <= {OP_NOP, 11'd0};
         end else begin
            ex_ir <= id_ir;
            if (w_use_a)                       reg_A <= w_fwd_a;
            if (is_b_imm4(w_id_op))            reg_B <= w_imm4;
            else if (is_a_hi(w_id_op))         reg_B <= w_imm8;
            else if (w_use_b)                  reg_B <= w_fwd_b;
            if (w_use_s)                       smdr  <= w_fwd_s;
         end
      end
   end

endmodule

// File: tb/tb_id_stage_p.sv
// Self-checking bench for id_stage_p: expected stage outputs are queued as each
// instruction is presented and compared after the issuing clock edge.
module tb_id_stage_p;
   localparam int unsigned DW = 16;
`ifdef ID_LOADUSE_STALL_EN
   localparam logic STALL_EN = 1'b1;
`else
   localparam logic STALL_EN = 1'b0;
`endif

   localparam logic [4:0] NOP = 5'd0,  HALT = 5'd1,  LOAD = 5'd2,  STORE = 5'd3,
                          MOVI = 5'd4, ADD = 5'd5,   ADDI = 5'd6,  SUB = 5'd8,
                          SUBI = 5'd9, CMP = 5'd11,  XOR = 5'd14,  SHL = 5'd15,
                          JUMP = 5'd19, JNC = 5'd25;

   typedef struct packed {
      logic [15:0]   ir;
      logic [DW-1:0] a;
      logic [DW-1:0] b;
      logic [DW-1:0] s;
   } obs_t;

   logic clock = 1'b0;
   logic reset, state, jump;
   logic [15:0] id_ir, mem_ir, wb_ir;
   logic [DW-1:0] ALUo, reg_C, reg_C1, d_datain;
   logic [8*DW-1:0] gr_flat;
   logic [15:0] ex_ir0, ex_ir1;
   logic [DW-1:0] reg_A0, reg_B0, smdr0, reg_A1, reg_B1, smdr1;
   logic id_stall0, id_stall1;

   obs_t sb[$];
   obs_t cur, e, g;
   int checks = 0;
   int failures = 0;

   always #5 clock = ~clock;

   id_stage_p #(.DW(DW), .IMM_SIGNED(0)) u0 (
      .clock(clock), .reset(reset), .state(state), .id_ir(id_ir), .mem_ir(mem_ir),
      .wb_ir(wb_ir), .ALUo(ALUo), .reg_C(reg_C), .reg_C1(reg_C1), .d_datain(d_datain),
      .gr_flat(gr_flat), .jump(jump), .ex_ir(ex_ir0), .reg_A(reg_A0), .reg_B(reg_B0),
      .smdr(smdr0), .id_stall(id_stall0));

   id_stage_p #(.DW(DW), .IMM_SIGNED(1)) u1 (
      .clock(clock), .reset(reset), .state(state), .id_ir(id_ir), .mem_ir(mem_ir),
      .wb_ir(wb_ir), .ALUo(ALUo), .reg_C(reg_C), .reg_C1(reg_C1), .d_datain(d_datain),
      .gr_flat(gr_flat), .jump(jump), .ex_ir(ex_ir1), .reg_A(reg_A1), .reg_B(reg_B1),
      .smdr(smdr1), .id_stall(id_stall1));

   function automatic logic [15:0] rr(input logic [4:0] op, input logic [2:0] d,
                                      input logic [2:0] s1, input logic [2:0] s2);
      return {op, d, 1'b0, s1, 1'b0, s2};
   endfunction

   function automatic logic [15:0] ri(input logic [4:0] op, input logic [2:0] d,
                                      input logic [7:0] imm);
      return {op, d, imm};
   endfunction

   function automatic logic [DW-1:0] grv(input int n);
      return 16'hA0A0 + 16'(n);
   endfunction

   task automatic tick(output obs_t exp_o, output obs_t got_o);
      @(posedge clock);
      #1;
      got_o = {ex_ir0, reg_A0, reg_B0, smdr0};
      exp_o = sb.pop_front();
   endtask

   task automatic test_reset;
      reset = 1'b0;
      #2;
      checks++;
      if ({ex_ir0, reg_A0, reg_B0, smdr0, id_stall0, ex_ir1, reg_A1, reg_B1, smdr1} !== '0) begin
         failures++;
         $display("FAIL reset_init: got %h %h %h %h %b want all zero", ex_ir0, reg_A0, reg_B0, smdr0, id_stall0);
      end
      id_ir = rr(ADD, 1, 2, 3);
      sb.push_back('0);
      tick(e, g);
      checks++;
      if (g !== e) begin failures++; $display("FAIL reset_hold: got %h want %h", g, e); end
      id_ir = '0;
      @(negedge clock);
      reset = 1'b1;
      cur = '0;
   endtask

   task automatic test_fwd_ex;
      id_ir = ri(ADDI, 1, 8'h05);
      cur.ir = id_ir; cur.a = grv(1); cur.b = 16'h0005;
      sb.push_back(cur); tick(e, g);
      checks++;
      if (g !== e) begin failures++; $display("FAIL addi_issue: got %h want %h", g, e); end
      id_ir = rr(ADD, 2, 1, 1); ALUo = 16'h0042;
      cur.ir = id_ir; cur.a = 16'h0042; cur.b = 16'h0042;
      sb.push_back(cur); tick(e, g);
      checks++;
      if (g !== e) begin failures++; $display("FAIL fwd_ex: got %h want %h", g, e); end
      id_ir = '0;
      cur.ir = '0;
      sb.push_back(cur); tick(e, g);
      checks++;
      if (g !== e) begin failures++; $display("FAIL nop_hold: got %h want %h", g, e); end
   endtask

   task automatic test_fwd_mem;
      id_ir = {STORE, 3'd3, 1'b0, 3'd5, 4'h7};
      mem_ir = rr(LOAD, 3, 0, 0); wb_ir = rr(ADD, 3, 0, 0);
      d_datain = 16'h1234; reg_C1 = 16'h5555; reg_C = 16'h7777;
      cur.ir = id_ir; cur.a = grv(5); cur.b = 16'h0007; cur.s = 16'h1234;
      sb.push_back(cur); tick(e, g);
      checks++;
      if (g !== e) begin failures++; $display("FAIL mem_load_beats_wb: got %h want %h", g, e); end
      mem_ir = rr(SUB, 3, 0, 0);
      cur.s = 16'h7777;
      sb.push_back(cur); tick(e, g);
      checks++;
      if (g !== e) begin failures++; $display("FAIL mem_alu_fwd: got %h want %h", g, e); end
      mem_ir = '0; wb_ir = rr(LOAD, 3, 0, 0);
      cur.s = 16'h5555;
      sb.push_back(cur); tick(e, g);
      checks++;
      if (g !== e) begin failures++; $display("FAIL wb_load_fwd: got %h want %h", g, e); end
      wb_ir = rr(CMP, 3, 0, 0);
      cur.s = grv(3);
      sb.push_back(cur); tick(e, g);
      checks++;
      if (g !== e) begin failures++; $display("FAIL no_fwd_cmp: got %h want %h", g, e); end
      wb_ir = '0;
   endtask

   task automatic test_priority;
      id_ir = ri(SUBI, 6, 8'hFF); mem_ir = rr(ADD, 6, 0, 0);
      cur.ir = id_ir; cur.a = 16'h7777; cur.b = 16'h00FF;
      sb.push_back(cur); tick(e, g);
      checks++;
      if (g !== e) begin failures++; $display("FAIL subi_mem_fwd: got %h want %h", g, e); end
      id_ir = rr(XOR, 1, 6, 2); wb_ir = rr(ADD, 2, 0, 0); ALUo = 16'h0042;
      cur.ir = id_ir; cur.a = 16'h0042; cur.b = 16'h5555;
      sb.push_back(cur); tick(e, g);
      checks++;
      if (g !== e) begin failures++; $display("FAIL ex_beats_mem: got %h want %h", g, e); end
      mem_ir = '0; wb_ir = '0; id_ir = '0;
      cur.ir = '0;
      sb.push_back(cur); tick(e, g);
      checks++;
      if (g !== e) begin failures++; $display("FAIL nop_hold2: got %h want %h", g, e); end
   endtask

   task automatic test_imm;
      id_ir = ri(MOVI, 7, 8'h80);
      cur.ir = id_ir; cur.a = grv(7); cur.b = 16'h0080;
      sb.push_back(cur); tick(e, g);
      checks++;
      if (g !== e) begin failures++; $display("FAIL movi_zext: got %h want %h", g, e); end
      checks++;
      if (reg_B1 !== 16'hFF80) begin failures++; $display("FAIL movi_sext: got %h want ff80", reg_B1); end
      id_ir = {SHL, 3'd2, 1'b0, 3'd4, 4'hF};
      cur.ir = id_ir; cur.a = grv(4); cur.b = 16'h000F;
      sb.push_back(cur); tick(e, g);
      checks++;
      if (g !== e) begin failures++; $display("FAIL shl_imm4: got %h want %h", g, e); end
      id_ir = ri(JNC, 4, 8'h7F);
      cur.ir = id_ir; cur.a = grv(4); cur.b = 16'h007F;
      sb.push_back(cur); tick(e, g);
      checks++;
      if (g !== e) begin failures++; $display("FAIL jnc_imm: got %h want %h", g, e); end
      checks++;
      if (reg_B1 !== 16'h007F) begin failures++; $display("FAIL jnc_sext_pos: got %h want 007f", reg_B1); end
      id_ir = {HALT, 11'h0};
      cur.ir = id_ir;
      sb.push_back(cur); tick(e, g);
      checks++;
      if (g !== e) begin failures++; $display("FAIL halt_hold: got %h want %h", g, e); end
   endtask

   task automatic test_state_hold;
      state = 1'b0;
      id_ir = rr(ADD, 1, 2, 3);
      sb.push_back(cur); tick(e, g);
      checks++;
      if (g !== e) begin failures++; $display("FAIL state_hold: got %h want %h", g, e); end
      id_ir = {JUMP, 11'h0}; jump = 1'b1;
      sb.push_back(cur); tick(e, g);
      checks++;
      if (g !== e) begin failures++; $display("FAIL state_hold_flush: got %h want %h", g, e); end
      state = 1'b1; jump = 1'b0;
   endtask

   task automatic test_flush;
      id_ir = rr(ADD, 1, 2, 3); jump = 1'b1;
      cur.ir = '0;
      sb.push_back(cur); tick(e, g);
      checks++;
      if (g !== e) begin failures++; $display("FAIL jump_flush: got %h want %h", g, e); end
      jump = 1'b0; id_ir = {JUMP, 11'h123};
      sb.push_back(cur); tick(e, g);
      checks++;
      if (g !== e) begin failures++; $display("FAIL jump_op_flush: got %h want %h", g, e); end
   endtask

   task automatic test_load_use;
      logic [15:0] ld;
      ld = {LOAD, 3'd4, 1'b0, 3'd1, 4'h2};
      id_ir = ld;
      cur.ir = id_ir; cur.a = grv(1); cur.b = 16'h0002;
      sb.push_back(cur); tick(e, g);
      checks++;
      if (g !== e) begin failures++; $display("FAIL load_issue: got %h want %h", g, e); end
      id_ir = rr(SUB, 5, 4, 0); state = 1'b0;
      #1;
      checks++;
      if (id_stall0 !== STALL_EN) begin failures++; $display("FAIL stall_outside_exec: got %b want %b", id_stall0, STALL_EN); end
      sb.push_back(cur); tick(e, g);
      checks++;
      if (g !== e) begin failures++; $display("FAIL stall_state_hold: got %h want %h", g, e); end
      state = 1'b1;
      #1;
      checks++;
      if (id_stall0 !== STALL_EN) begin failures++; $display("FAIL loaduse_stall: got %b want %b", id_stall0, STALL_EN); end
      cur.ir = STALL_EN ? 16'h0000 : id_ir;
      cur.a  = STALL_EN ? cur.a : grv(4);
      cur.b  = STALL_EN ? cur.b : grv(0);
      sb.push_back(cur); tick(e, g);
      checks++;
      if (g !== e) begin failures++; $display("FAIL loaduse_bubble: got %h want %h", g, e); end
      mem_ir = ld; d_datain = 16'h1234;
      #1;
      checks++;
      if (id_stall0 !== 1'b0) begin failures++; $display("FAIL stall_released: got %b want 0", id_stall0); end
      cur.ir = id_ir; cur.a = 16'h1234; cur.b = grv(0);
      sb.push_back(cur); tick(e, g);
      checks++;
      if (g !== e) begin failures++; $display("FAIL loaduse_fwd: got %h want %h", g, e); end
      mem_ir = '0;
      id_ir = ld;
      cur.ir = id_ir; cur.a = grv(1); cur.b = 16'h0002;
      sb.push_back(cur); tick(e, g);
      checks++;
      if (g !== e) begin failures++; $display("FAIL load_issue2: got %h want %h", g, e); end
      id_ir = rr(SUB, 5, 4, 0); jump = 1'b1;
      #1;
      checks++;
      if (id_stall0 !== 1'b0) begin failures++; $display("FAIL flush_kills_stall: got %b want 0", id_stall0); end
      cur.ir = '0;
      sb.push_back(cur); tick(e, g);
      checks++;
      if (g !== e) begin failures++; $display("FAIL flush_beats_stall: got %h want %h", g, e); end
      jump = 1'b0; id_ir = ld;
      cur.ir = id_ir; cur.a = grv(1); cur.b = 16'h0002;
      sb.push_back(cur); tick(e, g);
      checks++;
      if (g !== e) begin failures++; $display("FAIL load_issue3: got %h want %h", g, e); end
      id_ir = {STORE, 3'd4, 1'b0, 3'd1, 4'h3};
      #1;
      checks++;
      if (id_stall0 !== STALL_EN) begin failures++; $display("FAIL store_data_stall: got %b want %b", id_stall0, STALL_EN); end
      id_ir = rr(ADD, 5, 1, 2);
      #1;
      checks++;
      if (id_stall0 !== 1'b0) begin failures++; $display("FAIL no_hazard: got %b want 0", id_stall0); end
      cur.ir = id_ir; cur.a = grv(1); cur.b = grv(2);
      sb.push_back(cur); tick(e, g);
      checks++;
      if (g !== e) begin failures++; $display("FAIL load_nouse_issue: got %h want %h", g, e); end
   endtask

   task automatic test_reset_mid;
      checks++;
      if (ex_ir0[15:11] !== ADD) begin failures++; $display("FAIL pre_reset_add: got %h want ADD in EX", ex_ir0); end
      reset = 1'b0;
      #1;
      checks++;
      if ({ex_ir0, reg_A0, reg_B0, smdr0, id_stall0, ex_ir1, reg_A1, reg_B1, smdr1} !== '0) begin
         failures++;
         $display("FAIL async_reset: got %h %h %h %h %b want all zero", ex_ir0, reg_A0, reg_B0, smdr0, id_stall0);
      end
      @(negedge clock);
      reset = 1'b1;
      cur = '0;
      id_ir = rr(ADD, 2, 1, 1); ALUo = 16'h0042;
      cur.ir = id_ir; cur.a = grv(1); cur.b = grv(1);
      sb.push_back(cur); tick(e, g);
      checks++;
      if (g !== e) begin failures++; $display("FAIL post_reset_issue: got %h want %h", g, e); end
      checks++;
      if (sb.size() != 0) begin failures++; $display("FAIL scoreboard_drain: got %0d left want 0", sb.size()); end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "timeout");
   end

   initial begin
      reset = 1'b0; state = 1'b1; jump = 1'b0;
      id_ir = '0; mem_ir = '0; wb_ir = '0;
      ALUo = '0; reg_C = '0; reg_C1 = '0; d_datain = '0;
      for (int n = 0; n < 8; n++) gr_flat[n*DW +: DW] = grv(n);
      test_reset();
      test_fwd_ex();
      test_fwd_mem();
      test_priority();
      test_imm();
      test_state_hold();
      test_flush();
      test_load_use();
      test_reset_mid();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
